// File: rtl/qnet_tx_arb.sv
// Two-requester round-robin arbiter that streams a latched 192-bit frame as
// three 64-bit AXI-Stream beats, with stall timeout and link-down abort.
module qnet_tx_arb #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         user_clk_i,
  input  logic         user_rst_i,
  input  logic         channel_up_i,
  input  logic         fwd_req_i,
  input  logic [191:0] fwd_dt_i,
  output logic         fwd_ack_o,
  output logic         fwd_done_o,
  output logic         fwd_err_o,
  input  logic         loc_req_i,
  input  logic [191:0] loc_dt_i,
  output logic         loc_ack_o,
  output logic         loc_done_o,
  output logic         loc_err_o,
  output logic [63:0]  m_axi_tx_tdata_o,
  output logic         m_axi_tx_tvalid_o,
  output logic         m_axi_tx_tlast_o,
  input  logic         m_axi_tx_tready_i,
  output logic         busy_o,
  output logic [1:0]   grant_o,
  output logic [15:0]  pkt_cnt_o,
  output logic [7:0]   err_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, ABORT} state_e;

  localparam int SW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYC - 1);

  state_e         state_q, state_d;
  logic [191:0]   frame_q, frame_d;
  logic [1:0]     beat_q, beat_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_loc_q, last_loc_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic win_fwd, win_loc, grant_now;

  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      beat_q     <= '0;
      stall_q    <= '0;
      grant_q    <= '0;
      last_loc_q <= 1'b1;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      beat_q     <= beat_d;
      stall_q    <= stall_d;
      grant_q    <= grant_d;
      last_loc_q <= last_loc_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // On a tie fwd wins unless it was the last one served.
  always_comb begin
    win_fwd   = fwd_req_i && (!loc_req_i || last_loc_q);
    win_loc   = loc_req_i && !win_fwd;
    grant_now = (state_q == IDLE) && channel_up_i && !user_rst_i &&
                (fwd_req_i || loc_req_i);
    fwd_ack_o = grant_now && win_fwd;
    loc_ack_o = grant_now && win_loc;
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    grant_d    = grant_q;
    last_loc_d = last_loc_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          frame_d    = win_fwd ? fwd_dt_i : loc_dt_i;
          grant_d    = win_fwd ? 2'b01 : 2'b10;
          last_loc_d = !win_fwd;
          beat_d     = '0;
          stall_d    = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Link loss wins over any handshake in the same cycle.
        if (!channel_up_i) begin
          state_d   = ABORT;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end else if (m_axi_tx_tready_i) begin
          stall_d = '0;
          if (beat_q == 2'd2) begin
            beat_d    = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = DONE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          stall_d = stall_q + 1'b1;
          if (stall_q == STALL_LAST) begin
            state_d   = ABORT;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    m_axi_tx_tvalid_o = (state_q == SEND);
    m_axi_tx_tlast_o  = (state_q == SEND) && (beat_q == 2'd2);
    m_axi_tx_tdata_o  = '0;
    if (state_q == SEND) begin
      case (beat_q)
        2'd0:    m_axi_tx_tdata_o = frame_q[63:0];
        2'd1:    m_axi_tx_tdata_o = frame_q[127:64];
        2'd2:    m_axi_tx_tdata_o = frame_q[191:128];
        default: m_axi_tx_tdata_o = '0;
      endcase
    end
  end

  assign fwd_done_o = (state_q == DONE)  && grant_q[0];
  assign loc_done_o = (state_q == DONE)  && grant_q[1];
  assign fwd_err_o  = (state_q == ABORT) && grant_q[0];
  assign loc_err_o  = (state_q == ABORT) && grant_q[1];
  assign busy_o     = (state_q != IDLE);
  assign grant_o    = grant_q;
  assign pkt_cnt_o  = pkt_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_qnet_tx_arb.sv
// Directed bench for qnet_tx_arb: single packet, tie alternation, stalls,
// timeout abort, link-down abort and mid-packet reset.
module tb_qnet_tx_arb;

  logic         clk = 1'b0;
  logic         rst, chan_up;
  logic         fwd_req, fwd_ack, fwd_done, fwd_err;
  logic         loc_req, loc_ack, loc_done, loc_err;
  logic [191:0] fwd_dt, loc_dt;
  logic [63:0]  tdata;
  logic         tvalid, tlast, tready;
  logic         busy;
  logic [1:0]   grant;
  logic [15:0]  pkt_cnt;
  logic [7:0]   err_cnt;

  int checks = 0;
  int failures = 0;
  int hs;

  logic [191:0] fa, fb, fc;
  logic [1:0]   rdy_pat [7];
  int           beat_pat [7];

  always #5 clk = ~clk;

  qnet_tx_arb #(.TIMEOUT_CYC(8)) dut (
    .user_clk_i(clk), .user_rst_i(rst), .channel_up_i(chan_up),
    .fwd_req_i(fwd_req), .fwd_dt_i(fwd_dt), .fwd_ack_o(fwd_ack),
    .fwd_done_o(fwd_done), .fwd_err_o(fwd_err),
    .loc_req_i(loc_req), .loc_dt_i(loc_dt), .loc_ack_o(loc_ack),
    .loc_done_o(loc_done), .loc_err_o(loc_err),
    .m_axi_tx_tdata_o(tdata), .m_axi_tx_tvalid_o(tvalid),
    .m_axi_tx_tlast_o(tlast), .m_axi_tx_tready_i(tready),
    .busy_o(busy), .grant_o(grant), .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
  );

  function automatic logic [63:0] wd(logic [191:0] f, int b);
    return f[b*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chkw(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; chan_up = 1'b1; tready = 1'b1;
    fwd_req = 1'b0; loc_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    fa = {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    fb = {64'h2222_0000_0000_0003, 64'h1111_0000_0000_0002, 64'h0F0F_0000_0000_0001};
    fc = {64'h9000_0000_0000_00C3, 64'h8000_0000_0000_00C2, 64'h7000_0000_0000_00C1};
    fwd_dt = '0; loc_dt = '0;
    rdy_pat  = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    beat_pat = '{0, 1, 1, 1, 2, 2, 2};

    // Reset state
    do_reset();
    #1;
    chk1("rst_tvalid", tvalid, 1'b0);
    chk1("rst_tlast", tlast, 1'b0);
    chkw("rst_tdata", tdata, 64'h0);
    chkw("rst_grant", 64'(grant), 64'h0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_pkt", 64'(pkt_cnt), 64'h0);
    chkw("rst_err", 64'(err_cnt), 64'h0);

    // Single fwd packet, tready=1
    fwd_req = 1'b1; fwd_dt = fa;
    #1;
    chk1("t1_fwd_ack", fwd_ack, 1'b1);
    chk1("t1_loc_ack", loc_ack, 1'b0);
    tick();
    fwd_req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk1("t1_tvalid", tvalid, 1'b1);
      chkw("t1_tdata", tdata, wd(fa, b));
      chk1("t1_tlast", tlast, b == 2);
      chkw("t1_grant", 64'(grant), 64'h1);
      tick();
    end
    #1;
    chk1("t1_tvalid_drop", tvalid, 1'b0);
    chk1("t1_fwd_done", fwd_done, 1'b1);
    chkw("t1_pkt", 64'(pkt_cnt), 64'h1);
    chk1("t1_busy_done", busy, 1'b1);
    tick();
    #1;
    chk1("t1_busy_idle", busy, 1'b0);
    chkw("t1_grant_idle", 64'(grant), 64'h0);
    chk1("t1_done_clear", fwd_done, 1'b0);

    // Tie: fwd first, then loc, both requests kept high
    do_reset();
    fwd_req = 1'b1; loc_req = 1'b1; fwd_dt = fb; loc_dt = fc;
    #1;
    chk1("t2_fwd_ack", fwd_ack, 1'b1);
    chk1("t2_loc_ack", loc_ack, 1'b0);
    tick();
    for (int b = 0; b < 3; b++) begin
      #1;
      chk1("t2a_ack_ignored", fwd_ack | loc_ack, 1'b0);
      chkw("t2a_tdata", tdata, wd(fb, b));
      chk1("t2a_tlast", tlast, b == 2);
      chkw("t2a_grant", 64'(grant), 64'h1);
      tick();
    end
    #1;
    chk1("t2a_fwd_done", fwd_done, 1'b1);
    tick();
    #1;
    chk1("t2b_loc_ack", loc_ack, 1'b1);
    chk1("t2b_fwd_ack", fwd_ack, 1'b0);
    tick();
    fwd_req = 1'b0; loc_req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk1("t2b_tvalid", tvalid, 1'b1);
      chkw("t2b_tdata", tdata, wd(fc, b));
      chk1("t2b_tlast", tlast, b == 2);
      chkw("t2b_grant", 64'(grant), 64'h2);
      tick();
    end
    #1;
    chk1("t2b_loc_done", loc_done, 1'b1);
    chk1("t2b_fwd_done", fwd_done, 1'b0);
    chkw("t2_pkt", 64'(pkt_cnt), 64'h2);

    // tready toggling 1,0,0,1,0,0,1
    do_reset();
    fwd_req = 1'b1; fwd_dt = fa;
    #1;
    chk1("t3_ack", fwd_ack, 1'b1);
    tick();
    fwd_req = 1'b0;
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      tready = rdy_pat[c][0];
      #1;
      chk1("t3_tvalid", tvalid, 1'b1);
      chkw("t3_tdata", tdata, wd(fa, beat_pat[c]));
      chk1("t3_tlast", tlast, beat_pat[c] == 2);
      if (tvalid && tready) hs++;
      tick();
    end
    tready = 1'b1;
    #1;
    chkw("t3_handshakes", 64'(hs), 64'd3);
    chk1("t3_tvalid_drop", tvalid, 1'b0);
    chk1("t3_done", fwd_done, 1'b1);
    chkw("t3_pkt", 64'(pkt_cnt), 64'h1);

    // Stall timeout with TIMEOUT_CYC=8
    do_reset();
    fwd_req = 1'b1; fwd_dt = fb; tready = 1'b0;
    #1;
    chk1("t4_ack", fwd_ack, 1'b1);
    tick();
    fwd_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk1("t4_tvalid_stall", tvalid, 1'b1);
      chkw("t4_tdata_hold", tdata, wd(fb, 0));
      chk1("t4_no_err", fwd_err, 1'b0);
      tick();
    end
    #1;
    chk1("t4_tvalid_drop", tvalid, 1'b0);
    chk1("t4_tlast", tlast, 1'b0);
    chk1("t4_err", fwd_err, 1'b1);
    chkw("t4_err_cnt", 64'(err_cnt), 64'h1);
    chkw("t4_pkt", 64'(pkt_cnt), 64'h0);
    chk1("t4_busy", busy, 1'b1);
    tick();
    tready = 1'b1;
    #1;
    chk1("t4_idle", busy, 1'b0);
    chk1("t4_err_clear", fwd_err, 1'b0);

    // Link drop during word1, then request while link is down
    do_reset();
    fwd_req = 1'b1; fwd_dt = fa;
    #1;
    chk1("t5_ack", fwd_ack, 1'b1);
    tick();
    fwd_req = 1'b0;
    #1;
    chkw("t5_w0", tdata, wd(fa, 0));
    tick();
    chan_up = 1'b0;
    #1;
    chkw("t5_w1", tdata, wd(fa, 1));
    tick();
    #1;
    chk1("t5_tvalid_drop", tvalid, 1'b0);
    chk1("t5_err", fwd_err, 1'b1);
    chk1("t5_no_done", fwd_done, 1'b0);
    chkw("t5_err_cnt", 64'(err_cnt), 64'h1);
    chkw("t5_pkt", 64'(pkt_cnt), 64'h0);
    tick();
    loc_req = 1'b1; loc_dt = fc;
    #1;
    chk1("t5_no_ack_down0", loc_ack, 1'b0);
    tick();
    #1;
    chk1("t5_no_ack_down1", loc_ack, 1'b0);
    chk1("t5_idle", busy, 1'b0);
    tick();
    chan_up = 1'b1;
    #1;
    chk1("t5_ack_up", loc_ack, 1'b1);
    tick();
    loc_req = 1'b0;
    #1;
    chkw("t5_loc_w0", tdata, wd(fc, 0));
    chkw("t5_loc_grant", 64'(grant), 64'h2);

    // Reset during word1, then a tie goes to fwd
    do_reset();
    fwd_req = 1'b1; fwd_dt = fb;
    #1;
    chk1("t6_ack", fwd_ack, 1'b1);
    tick();
    fwd_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chkw("t6_w1", tdata, wd(fb, 1));
    tick();
    rst = 1'b0;
    #1;
    chk1("t6_tvalid", tvalid, 1'b0);
    chkw("t6_tdata", tdata, 64'h0);
    chkw("t6_grant", 64'(grant), 64'h0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_no_done", fwd_done | loc_done, 1'b0);
    chk1("t6_no_err", fwd_err | loc_err, 1'b0);
    chkw("t6_pkt", 64'(pkt_cnt), 64'h0);
    chkw("t6_err_cnt", 64'(err_cnt), 64'h0);
    fwd_req = 1'b1; loc_req = 1'b1; fwd_dt = fc; loc_dt = fa;
    #1;
    chk1("t6_tie_fwd", fwd_ack, 1'b1);
    chk1("t6_tie_loc", loc_ack, 1'b0);
    tick();
    fwd_req = 1'b0; loc_req = 1'b0;
    #1;
    chkw("t6_new_grant", 64'(grant), 64'h1);
    chkw("t6_new_w0", tdata, wd(fc, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qnet_tx_arb.md
QNET_TX_ARB -- requirements
Module: qnet_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, the maximum number of consecutive cycles a beat may stall on tready before the packet is aborted.
REQ-002 SHALL have port user_clk_i, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port user_rst_i, input, 1 bit, the reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port channel_up_i, input, 1 bit, TX link up (already in the user_clk_i domain).
REQ-005 SHALL have forward-requester ports fwd_req_i (in, 1), fwd_dt_i (in, 192), fwd_ack_o (out, 1), fwd_done_o (out, 1), fwd_err_o (out, 1).
REQ-006 SHALL have local-requester ports loc_req_i (in, 1), loc_dt_i (in, 192), loc_ack_o (out, 1), loc_done_o (out, 1), loc_err_o (out, 1).
REQ-007 SHALL have TX master ports m_axi_tx_tdata_o (out, 64), m_axi_tx_tvalid_o (out, 1), m_axi_tx_tlast_o (out, 1), m_axi_tx_tready_i (in, 1).
REQ-008 SHALL have status ports busy_o (out, 1), grant_o (out, 2: 01=fwd, 10=loc, 00=none), pkt_cnt_o (out, 16), err_cnt_o (out, 8).

Function
REQ-009 SHALL implement states IDLE, SEND, DONE, ABORT.
REQ-010 IDLE: SHALL sample requests only when channel_up_i=1; all requests SHALL be ignored in every other state.
REQ-011 Arbitration SHALL be round-robin with a last_grant register: on a tie, the requester not granted last wins; the register resets to loc, so fwd wins the first tie.
REQ-012 On grant in cycle N: the winner's 192-bit frame SHALL be latched, the winner's ack SHALL pulse for one cycle in N, grant_o SHALL be set, and the state SHALL move to SEND.
REQ-013 m_axi_tx_tvalid_o SHALL first assert in cycle N+1 with word0.
REQ-014 Beat order SHALL be word0=dt[63:0], word1=dt[127:64], word2=dt[191:128]; m_axi_tx_tlast_o=1 only with word2.
REQ-015 The beat counter (0..2) SHALL advance only on tvalid&tready; tdata and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-016 Back-to-back beats SHALL be possible: with tready held at 1, a packet SHALL occupy exactly 3 consecutive tvalid cycles.
REQ-017 Word2 accepted: tvalid SHALL drop next cycle, state goes to DONE, the winner's done SHALL pulse one cycle, pkt_cnt_o SHALL increment (wraps at 16 bits).
REQ-018 DONE SHALL return to IDLE, giving one dead cycle between packets, so the minimum packet period is 5 cycles.
REQ-019 Stall counter SHALL clear on every accepted beat and increment each cycle tvalid=1 and tready=0.
REQ-020 On stall count reaching TIMEOUT_CYC: the state SHALL move to ABORT.
REQ-021 channel_up_i=0 in any SEND cycle SHALL also move the state to ABORT; link-down takes precedence over a same-cycle handshake.
REQ-022 ABORT: tvalid and tlast SHALL be 0, the winner's err SHALL pulse one cycle, err_cnt_o SHALL increment (saturating at 255), pkt_cnt_o SHALL be unchanged; next state is IDLE.
REQ-023 Abort SHALL be the only case where tvalid drops without a handshake.
REQ-024 busy_o SHALL be 1 in SEND, DONE and ABORT; grant_o SHALL clear on return to IDLE.
REQ-025 Requesters hold req until their ack and drop it the cycle after; a req still high in IDLE SHALL be treated as a new packet.

Reset
REQ-026 With user_rst_i=1 at a clock edge: state IDLE; all outputs 0 (tdata 0, grant_o 00, pkt_cnt_o 0, err_cnt_o 0); stall counter 0; last_grant=loc.
REQ-027 Reset mid-packet SHALL drop tvalid in the next cycle without any done or err pulse.

Verification
REQ-028 Single fwd request, tready=1, frame 0x...AA/BB/CC: fwd_ack at N; tdata AA, BB, CC at N+1..N+3 with tlast at N+3; fwd_done at N+4; pkt_cnt_o=1.
REQ-029 fwd and loc requests high together, held for two packets: order fwd, loc; grants alternate; each packet shows 3 beats; pkt_cnt_o=2.
REQ-030 tready toggling 1,0,0,1,...: each word holds stable across stalls; 3 handshakes total; tlast only on word2.
REQ-031 TIMEOUT_CYC=8, tready held 0 after the grant: tvalid drops after 8 stall cycles; err pulses; err_cnt_o=1; pkt_cnt_o=0.
REQ-032 channel_up_i falls during word1: ABORT next cycle with err pulse; a request made with channel_up_i=0 gets no ack until the link returns.
REQ-033 user_rst_i asserted during word1: all outputs 0 next cycle, no done/err; a new request then wins as fwd on a tie.
